// File: rtl/pci_pkg.sv
// ============================================================================
// Module   : pci_pkg
// Purpose  : Bus phase encodings and command codes shared by the initiator
//            and target controllers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_TURN   = 3'd2,
    ST_DATA   = 3'd3,
    ST_FINISH = 3'd4
  } pci_state_e;

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_READ  = 4'd1;

  // Any code other than CMD_READ is handled as a write.
  function automatic logic is_read(input logic [3:0] cmd);
    return (cmd == CMD_READ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pci_wait_counter.sv
// ============================================================================
// Module   : pci_wait_counter
// Purpose  : Data-phase wait counter with clear, enable and terminal count
//            at TIMEOUT-1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_wait_counter #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [3:0] TC_VALUE = 4'(TIMEOUT - 1);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VALUE);

endmodule

`default_nettype wire

// File: rtl/initiator_controller.sv
// ============================================================================
// Module   : initiator_controller
// Purpose  : Single-data-phase bus initiator with master-abort timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module initiator_controller
  import pci_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [2:0]  state,
  inout  wire  [31:0] AD,
  output logic [3:0]  C_BE,
  output logic        frame,
  output logic        irdy,
  output logic        fvalid,
  input  logic        devsel,
  input  logic        trdy,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [31:0] rdata
);

  pci_state_e  state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        abort_q, abort_d;
  logic [31:0] rdata_q, rdata_d;

  logic        ad_oe;
  logic [31:0] ad_out;
  logic        w_tc;
  logic        w_complete;

  // A target response counts only when both strobes are a solid logic 0.
  assign w_complete = (devsel == 1'b0) && (trdy == 1'b0);

  pci_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != ST_DATA),
    .en_i  (state_q == ST_DATA),
    .tc_o  (w_tc)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    abort_d = abort_q;
    rdata_d = rdata_q;
    ad_oe   = 1'b0;
    ad_out  = addr_q;
    C_BE    = 4'd0;
    frame   = 1'b1;
    irdy    = 1'b1;
    done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cmd_d   = cmd;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          abort_d = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ad_oe   = 1'b1;
        ad_out  = addr_q;
        C_BE    = cmd_q;
        frame   = 1'b0;
        state_d = is_read(cmd_q) ? ST_TURN : ST_DATA;
      end
      ST_TURN: begin
        C_BE    = be_q;
        frame   = 1'b0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        irdy = 1'b0;
        C_BE = be_q;
        if (!is_read(cmd_q)) begin
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end
        // Completion takes priority over a timeout on the same cycle.
        if (w_complete) begin
          if (is_read(cmd_q)) begin
            rdata_d = AD;
          end
          abort_d = 1'b0;
          state_d = ST_FINISH;
        end else if (w_tc) begin
          abort_d = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      abort_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
    end
  end

  assign AD     = ad_oe ? ad_out : 32'bz;
  assign state  = state_q;
  assign fvalid = ~frame;
  assign busy   = (state_q != ST_IDLE);
  assign abort  = abort_q;
  assign rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_initiator_controller.sv
// ============================================================================
// Module   : tb_initiator_controller
// Purpose  : Directed self-checking bench with a simple target at address 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_initiator_controller;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [2:0]  state;
  tri1  [31:0] AD;
  logic [3:0]  C_BE;
  logic        frame;
  logic        irdy;
  logic        fvalid;
  logic        devsel;
  logic        trdy;
  logic        busy;
  logic        done;
  logic        abort;
  logic [31:0] rdata;

  int n_cmp;
  int n_err;

  initiator_controller #(
    .TIMEOUT (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .cmd    (cmd),
    .addr   (addr),
    .wdata  (wdata),
    .be     (be),
    .state  (state),
    .AD     (AD),
    .C_BE   (C_BE),
    .frame  (frame),
    .irdy   (irdy),
    .fvalid (fvalid),
    .devsel (devsel),
    .trdy   (trdy),
    .busy   (busy),
    .done   (done),
    .abort  (abort),
    .rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Target model: decodes on the bus, responds at address 1 after t_wait data cycles.
  logic        t_in, t_resp, t_drv;
  logic [31:0] t_addr, mem;
  logic [3:0]  t_cmd;
  int          t_dcnt, t_wait;

  assign devsel = t_resp ? 1'b0 : 1'b1;
  assign trdy   = t_resp ? 1'b0 : 1'b1;
  assign AD     = t_drv ? mem : 32'bz;

  always @(negedge clk) begin
    if (!rst_n) begin
      t_in   = 1'b0;
      t_resp = 1'b0;
      t_drv  = 1'b0;
    end else if (!frame && !t_in) begin
      t_in   = 1'b1;
      t_addr = AD;
      t_cmd  = C_BE;
      t_dcnt = 0;
    end else if (frame && irdy) begin
      t_in   = 1'b0;
      t_resp = 1'b0;
      t_drv  = 1'b0;
    end else if (!irdy && t_in) begin
      if (t_addr == 32'd1 && t_dcnt >= t_wait && !t_resp) begin
        t_resp = 1'b1;
        if (t_cmd == 4'd1) begin
          t_drv = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (C_BE[i]) mem[8*i +: 8] = AD[8*i +: 8];
          end
        end
      end
      t_dcnt++;
    end
  end

  logic [31:0] trace;
  int          done_cyc;
  logic        ab_v;
  logic [31:0] ta_ad;

  // Issues one request and records the state per cycle until one cycle after done.
  task automatic run(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w,
                     input logic [3:0] b, input int tw);
    @(negedge clk);
    cmd = c; addr = a; wdata = w; be = b; t_wait = tw; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    trace = 32'd0; done_cyc = 0; ab_v = 1'b0; ta_ad = 32'd0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      trace = {trace[27:0], 1'b0, state};
      if (state == 3'd2) ta_ad = AD;
      if (done) begin
        done_cyc = k;
        ab_v = abort;
        @(negedge clk);
        trace = {trace[27:0], 1'b0, state};
        break;
      end
    end
    if (done_cyc == 0) check("done_bound", 32'd0, 32'd1);
  endtask

  int n_done;

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; req = 1'b0; cmd = 4'd0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    t_wait = 0; mem = 32'hAAAA_AAAA;
    repeat (2) @(negedge clk);

    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_frame_irdy", {30'd0, frame, irdy}, 32'd3);
    check("rst_flags", {28'd0, busy, done, abort, fvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_cbe", {28'd0, C_BE}, 32'd0);
    check("rst_AD_released", AD, 32'hFFFF_FFFF);
    rst_n = 1'b1;

    run(4'd1, 32'd1, 32'd0, 4'hF, 0);
    check("rd_trace", trace, 32'h0001_2340);
    check("rd_latency", done_cyc, 32'd4);
    check("rd_data", rdata, 32'hAAAA_AAAA);
    check("rd_abort", {31'd0, ab_v}, 32'd0);
    check("rd_turn_AD", ta_ad, 32'hFFFF_FFFF);

    run(4'd0, 32'd1, 32'h1234_5678, 4'b0101, 0);
    check("wr_trace", trace, 32'h0000_1340);
    check("wr_latency", done_cyc, 32'd3);
    check("wr_mem", mem, 32'hAA34_AA78);
    check("wr_abort", {31'd0, ab_v}, 32'd0);

    run(4'd1, 32'd2, 32'd0, 4'hF, 0);
    check("ma_trace", trace, 32'h1233_3340);
    check("ma_abort", {31'd0, ab_v}, 32'd1);
    check("ma_rdata_held", rdata, 32'hAAAA_AAAA);
    check("ma_abort_held", {31'd0, abort}, 32'd1);

    mem = 32'h5A5A_0F0F;
    run(4'd1, 32'd1, 32'd0, 4'hF, 3);
    check("last_cyc_trace", trace, 32'h1233_3340);
    check("last_cyc_abort", {31'd0, ab_v}, 32'd0);
    check("last_cyc_rdata", rdata, 32'h5A5A_0F0F);

    mem = 32'h1111_1111;
    run(4'd1, 32'd1, 32'd0, 4'hF, 4);
    check("late_abort", {31'd0, ab_v}, 32'd1);
    check("late_rdata_held", rdata, 32'h5A5A_0F0F);

    // Reset asserted in the middle of a data phase.
    @(negedge clk);
    cmd = 4'd0; addr = 32'd2; wdata = 32'h5555_5555; be = 4'hF; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 check("pre_rst_state", {29'd0, state}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_state", {29'd0, state}, 32'd0);
    check("mid_rst_frame_irdy", {30'd0, frame, irdy}, 32'd3);
    check("mid_rst_flags", {28'd0, busy, done, abort, fvalid}, 32'd0);
    check("mid_rst_AD", AD, 32'hFFFF_FFFF);
    check("mid_rst_rdata", rdata, 32'd0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid_rst_no_done", n_done, 32'd0);
    rst_n = 1'b1;

    run(4'd0, 32'd1, 32'hCAFE_BABE, 4'hF, 1);
    check("post_rst_trace", trace, 32'h0001_3340);
    check("post_rst_mem", mem, 32'hCAFE_BABE);
    check("post_rst_abort", {31'd0, ab_v}, 32'd0);

    // req held high: back-to-back writes, each separated by one idle cycle.
    @(negedge clk);
    cmd = 4'd0; addr = 32'd1; wdata = 32'h0000_1234; be = 4'b0011; t_wait = 0; req = 1'b1;
    @(posedge clk);
    trace = 32'd0; n_done = 0;
    repeat (8) begin
      @(negedge clk);
      trace = {trace[27:0], 1'b0, state};
      if (done) n_done++;
    end
    req = 1'b0;
    check("b2b_trace", trace, 32'h1340_1340);
    check("b2b_done_count", n_done, 32'd2);
    check("b2b_mem", mem, 32'hCAFE_1234);
    repeat (6) @(negedge clk);
    check("final_idle", {29'd0, state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
